// File: rtl/opalkelly_pipe_mux.sv
// opalkelly_pipe_mux: round-robin packetising mux of CHANNELS FIFO streams onto one pipe-out stream
// Ports: sys_clk/sys_rst clock and async active-high reset; mux_en gates new grants;
//   ch_level/ch_valid/ch_data in, ch_ready out: per-channel FIFO side, channel 0 in the LSBs;
//   tx_valid/tx_data out, tx_ready in: registered valid/ready output stream;
//   busy: burst in progress; grant: current or last granted channel.
module opalkelly_pipe_mux #(
    parameter int CHANNELS    = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int LEVEL_WIDTH = 11,
    parameter int BURST_MAX   = 64
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    input  logic                            mux_en,
    input  logic [CHANNELS*LEVEL_WIDTH-1:0] ch_level,
    input  logic [CHANNELS-1:0]             ch_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0]  ch_data,
    output logic [CHANNELS-1:0]             ch_ready,
    input  logic                            tx_ready,
    output logic                            tx_valid,
    output logic [DATA_WIDTH-1:0]           tx_data,
    output logic                            busy,
    output logic [7:0]                      grant
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int MW = LEVEL_WIDTH > DATA_WIDTH ? LEVEL_WIDTH : DATA_WIDTH;
    localparam int HW = DATA_WIDTH - 8;
    localparam logic [1:0] S_IDLE = 2'd0, S_HDR1 = 2'd1, S_DATA = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [7:0]             grant_q, grant_d, last_q, last_d;
    logic [DATA_WIDTH-1:0]  len_q, len_d, tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   slot_free, found;
    logic [7:0]             sel;
    logic [LEVEL_WIDTH-1:0] sel_level;
    logic [MW-1:0]          sel_ext;
    logic [CW-1:0]          g;
    int                     idx;

    assign slot_free = ~tx_valid_q | tx_ready;
    assign g         = grant_q[CW-1:0];
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign grant     = grant_q;
    assign busy      = (state_q != S_IDLE) | tx_valid_q;

    // first non-empty channel after the last grant, wrapping
    always_comb begin
        found     = 1'b0;
        sel       = '0;
        sel_level = '0;
        idx       = 0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = (int'(last_q) + i) % CHANNELS;
            if (!found && ch_level[idx*LEVEL_WIDTH +: LEVEL_WIDTH] != '0) begin
                found     = 1'b1;
                sel       = 8'(idx);
                sel_level = ch_level[idx*LEVEL_WIDTH +: LEVEL_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        len_d      = len_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q & ~tx_ready;
        ch_ready   = '0;
        sel_ext    = MW'(sel_level);
        if (state_q == S_IDLE) begin
            if (mux_en && found && slot_free) begin
                grant_d    = sel;
                last_d     = sel;
                len_d      = DATA_WIDTH'(sel_ext > MW'(BURST_MAX) ? MW'(BURST_MAX) : sel_ext);
                tx_data_d  = {8'hA5, HW'(sel)};
                tx_valid_d = 1'b1;
                state_d    = S_HDR1;
            end
        end else if (state_q == S_HDR1) begin
            if (slot_free) begin
                tx_data_d  = len_q;
                tx_valid_d = 1'b1;
                state_d    = S_DATA;
            end
        end else begin
            // pop strobe follows the output slot so a stalled output never drops a word
            ch_ready[g] = slot_free;
            if (ch_valid[g] && slot_free) begin
                tx_data_d  = ch_data[int'(g)*DATA_WIDTH +: DATA_WIDTH];
                tx_valid_d = 1'b1;
                len_d      = len_q - DATA_WIDTH'(1);
                state_d    = len_q == DATA_WIDTH'(1) ? S_IDLE : S_DATA;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            last_q     <= 8'(CHANNELS - 1);
            len_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            len_q      <= len_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end
endmodule

// File: tb/tb_opalkelly_pipe_mux.sv
// tb_opalkelly_pipe_mux: directed and randomized checks of opalkelly_pipe_mux against a packet-level model
module tb_opalkelly_pipe_mux;
    localparam int C = 4, DW = 16, LW = 11, BM = 64;

    logic              sys_clk = 1'b0, sys_rst = 1'b1, mux_en = 1'b0, tx_ready = 1'b1;
    logic [C*LW-1:0]   ch_level;
    logic [C-1:0]      ch_valid, ch_ready;
    logic [C*DW-1:0]   ch_data;
    logic              tx_valid, busy;
    logic [DW-1:0]     tx_data;
    logic [7:0]        grant;

    always #5 sys_clk = ~sys_clk;

    opalkelly_pipe_mux #(.CHANNELS(C), .DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .BURST_MAX(BM)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .mux_en(mux_en), .ch_level(ch_level),
        .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready), .tx_ready(tx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .busy(busy), .grant(grant)
    );

    logic [DW-1:0] mem [C][1024];
    int            wr[C], rd[C], mrd[C], gap[C];
    logic [DW-1:0] obs[$];
    int            obs_cyc[$];
    int            cyc = 0, checks = 0, errors = 0, rdy_pct = 100, gap_pct = 0, mlast = C - 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int c = 0; c < C; c++) begin
            ch_level[c*LW +: LW] = LW'(wr[c] - rd[c]);
            ch_valid[c]          = (wr[c] > rd[c]) && gap[c] == 0;
            ch_data[c*DW +: DW]  = wr[c] > rd[c] ? mem[c][rd[c]] : '0;
        end
    endtask

    task automatic push(input int c, input logic [DW-1:0] v);
        mem[c][wr[c]] = v;
        wr[c]++;
    endtask

    function automatic bit pending();
        for (int c = 0; c < C; c++) if (wr[c] != rd[c]) return 1'b1;
        return 1'b0;
    endfunction

    // sampled at negedge; inputs change #1 after posedge
    task automatic step();
        logic          xfer, stall;
        logic [DW-1:0] w;
        logic [C-1:0]  pop;
        xfer  = tx_valid & tx_ready;
        stall = tx_valid & ~tx_ready;
        w     = tx_data;
        pop   = ch_ready & ch_valid;
        if (stall) chk("ready_while_stalled", 64'(ch_ready), 64'(0));
        @(posedge sys_clk);
        #1;
        cyc++;
        if (xfer) begin
            obs.push_back(w);
            obs_cyc.push_back(cyc);
        end
        for (int c = 0; c < C; c++) begin
            if (pop[c]) rd[c]++;
            if (gap[c] > 0) gap[c]--;
            else if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) gap[c] = int'($urandom_range(3, 1));
        end
        tx_ready = int'($urandom_range(99)) < rdy_pct;
        drive();
        @(negedge sys_clk);
        if (stall) begin
            chk("hold_valid", 64'(tx_valid), 64'(1));
            chk("hold_data", 64'(tx_data), 64'(w));
        end
    endtask

    task automatic run_idle(input string tag);
        int n;
        n = 0;
        while ((busy || pending()) && n < 5000) begin
            step();
            n++;
        end
        chk({tag, "_idle"}, 64'(n < 5000), 64'(1));
    endtask

    task automatic step_until_obs(input int k);
        int n;
        n = 0;
        while (obs.size() < k && n < 500) begin
            step();
            n++;
        end
        chk("reach_mid_burst", 64'(n < 500), 64'(1));
    endtask

    // packet-level expectation: round robin over channels with words left, bursts capped at BM
    task automatic model_check(input string tag);
        logic [DW-1:0] exp[$];
        int c, n;
        bit any;
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int i = 1; i <= C; i++) begin
                c = (mlast + i) % C;
                if (!any && wr[c] > mrd[c]) begin
                    any   = 1'b1;
                    mlast = c;
                    n     = wr[c] - mrd[c] > BM ? BM : wr[c] - mrd[c];
                    exp.push_back(16'hA500 | 16'(c));
                    exp.push_back(16'(n));
                    for (int k = 0; k < n; k++) begin
                        exp.push_back(mem[c][mrd[c]]);
                        mrd[c]++;
                    end
                end
            end
        end
        chk({tag, "_count"}, 64'(obs.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < obs.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), 64'(obs[i]), 64'(exp[i]));
        obs.delete();
        obs_cyc.delete();
    endtask

    task automatic reset_dut();
        sys_rst = 1'b1;
        for (int c = 0; c < C; c++) begin
            wr[c] = 0; rd[c] = 0; mrd[c] = 0; gap[c] = 0;
        end
        mlast = C - 1;
        obs.delete();
        obs_cyc.delete();
        drive();
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        int rem;
        mux_en = 1'b1;
        reset_dut();
        @(negedge sys_clk);
        chk("rst_tx_valid", 64'(tx_valid), 64'(0));
        chk("rst_tx_data", 64'(tx_data), 64'(0));
        chk("rst_ch_ready", 64'(ch_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));

        push(0, 16'h0011); push(0, 16'h0022); push(0, 16'h0033);
        drive();
        run_idle("t1");
        chk("t1_hdr0", 64'(obs[0]), 64'hA500);
        chk("t1_hdr1", 64'(obs[1]), 64'h0003);
        chk("t1_last", 64'(obs[4]), 64'h0033);
        chk("t1_consecutive", 64'(obs_cyc[4] - obs_cyc[0]), 64'(4));
        chk("t1_busy_low", 64'(busy), 64'(0));
        model_check("t1");

        for (int i = 0; i < 100; i++) push(2, DW'($urandom));
        drive();
        run_idle("t2");
        chk("t2_hdr0a", 64'(obs[0]), 64'hA502);
        chk("t2_len_a", 64'(obs[1]), 64'h0040);
        chk("t2_hdr0b", 64'(obs[66]), 64'hA502);
        chk("t2_len_b", 64'(obs[67]), 64'h0024);
        chk("t2_no_bubble", 64'(obs_cyc[103] - obs_cyc[0]), 64'(103));
        model_check("t2");

        reset_dut();
        for (int r = 0; r < 2; r++) begin
            push(1, DW'($urandom)); push(1, DW'($urandom));
            push(3, DW'($urandom)); push(3, DW'($urandom));
            drive();
            run_idle("t3");
            chk("t3_first_ch1", 64'(obs[0]), 64'hA501);
            chk("t3_second_ch3", 64'(obs[4]), 64'hA503);
            model_check("t3");
        end

        rdy_pct = 50;
        for (int i = 0; i < 10; i++) push(1, DW'($urandom));
        drive();
        run_idle("t4");
        model_check("t4");

        for (int r = 0; r < 6; r++) begin
            rdy_pct = int'($urandom_range(100, 30));
            gap_pct = int'($urandom_range(20));
            for (int c = 0; c < C; c++)
                if (c == r % C || $urandom_range(1) == 1)
                    repeat (int'($urandom_range(80, 1))) push(c, DW'($urandom));
            drive();
            run_idle("rnd");
            model_check($sformatf("rnd%0d", r));
        end
        rdy_pct = 100;
        gap_pct = 0;
        for (int c = 0; c < C; c++) gap[c] = 0;

        for (int i = 0; i < 8; i++) push(0, DW'($urandom));
        drive();
        step_until_obs(3);
        gap[0] = 5;
        drive();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) chk("t5_gap_quiet", 64'(tx_valid), 64'(0));
            step();
        end
        run_idle("t5");
        model_check("t5");

        reset_dut();
        for (int i = 0; i < 10; i++) push(0, DW'($urandom));
        for (int i = 0; i < 5; i++) push(1, DW'($urandom));
        drive();
        step_until_obs(4);
        mux_en = 1'b0;
        repeat (60) step();
        chk("t6_one_burst", 64'(obs.size()), 64'(12));
        chk("t6_hdr0", 64'(obs[0]), 64'hA500);
        chk("t6_busy_low", 64'(busy), 64'(0));
        chk("t6_ch1_untouched", 64'(wr[1] - rd[1]), 64'(5));
        mux_en = 1'b1;
        run_idle("t6");
        model_check("t6");

        reset_dut();
        for (int i = 0; i < 20; i++) push(0, DW'($urandom));
        drive();
        step_until_obs(4);
        sys_rst = 1'b1;
        #1;
        chk("t7_rst_valid", 64'(tx_valid), 64'(0));
        chk("t7_rst_ready", 64'(ch_ready), 64'(0));
        chk("t7_rst_busy", 64'(busy), 64'(0));
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        rem = wr[0] - rd[0];
        obs.delete();
        obs_cyc.delete();
        drive();
        run_idle("t7");
        chk("t7_hdr0", 64'(obs[0]), 64'hA500);
        chk("t7_len", 64'(obs[1]), 64'(rem));
        chk("t7_count", 64'(obs.size()), 64'(rem + 2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
